// File: rtl/vis_frame_ctrl_if.sv
// Signal bundle between the video source/config master and vis_frame_ctrl.
// The master drives the video stream and config strobes; the controller (slave) returns markers and status.
interface vis_frame_ctrl_if #(
    parameter int XW = 11,
    parameter int YW = 11
);
    logic          in_de;
    logic          in_hs;
    logic          in_vs;
    logic          cfg_wr;
    logic [7:0]    cfg_thr;
    logic          cfg_en;
    logic          err_clr;

    logic          out_de;
    logic          out_hs;
    logic          out_vs;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          proc_en;
    logic [7:0]    thr;
    logic          cfg_ack;
    logic [1:0]    state;
    logic [7:0]    frame_cnt;
    logic [XW-1:0] meas_w;
    logic [YW-1:0] meas_h;
    logic          res_err;

    modport master (
        output in_de, in_hs, in_vs, cfg_wr, cfg_thr, cfg_en, err_clr,
        input  out_de, out_hs, out_vs, x, y, sof, eol, eof, proc_en,
        input  thr, cfg_ack, state, frame_cnt, meas_w, meas_h, res_err
    );

    modport slave (
        input  in_de, in_hs, in_vs, cfg_wr, cfg_thr, cfg_en, err_clr,
        output out_de, out_hs, out_vs, x, y, sof, eol, eof, proc_en,
        output thr, cfg_ack, state, frame_cnt, meas_w, meas_h, res_err
    );
endinterface

// File: rtl/vis_frame_ctrl.sv
// Frame-level controller: tracks de/hs/vs, emits pixel coordinates and frame/line markers one cycle
// late, applies shadowed threshold/enable only at vsync, and measures the incoming resolution.
module vis_frame_ctrl #(
    parameter int H_RES = 64,
    parameter int V_RES = 64,
    parameter int XW    = 11,
    parameter int YW    = 11
) (
    input  logic            clk,
    input  logic            rst,
    vis_frame_ctrl_if.slave vif
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic [XW-1:0] H_RES_L = XW'(H_RES);
    localparam logic [YW-1:0] V_RES_L = YW'(V_RES);
    localparam logic [YW-1:0] V_LAST  = YW'(V_RES - 1);

    state_e        state_q;
    logic          vs_d_q;
    logic          de_d_q;
    logic          vs_rise;
    logic          de_fall;
    logic          in_sync;

    logic [XW-1:0] x_q;
    logic [XW-1:0] x_d;
    logic [XW-1:0] x_inc;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;

    logic          out_de_q;
    logic          out_hs_q;
    logic          out_vs_q;

    logic [XW-1:0] meas_w_q;
    logic [YW-1:0] meas_h_q;
    logic [7:0]    frame_cnt_q;
    logic          res_err_q;
    logic          res_err_d;
    logic          err_set;

    logic [7:0]    pend_thr_q;
    logic          pend_en_q;
    logic          pend_flag_q;
    logic [7:0]    thr_q;
    logic          act_en_q;
    logic          cfg_ack_q;
    logic          cfg_apply;

    assign vs_rise = vif.in_vs & ~vs_d_q;
    assign de_fall = ~vif.in_de & de_d_q;
    // Encoding 3 is never entered; treating it as SYNC keeps the datapath gated if it ever appears.
    assign in_sync = (state_q != ST_WAIT) && (state_q != ST_ACTIVE);
    assign x_inc   = x_q + XW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d_q <= 1'b0;
            de_d_q <= 1'b0;
        end else begin
            vs_d_q <= vif.in_vs;
            de_d_q <= vif.in_de;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:   if (vs_rise) state_q <= ST_WAIT;
                ST_WAIT:   if (!vs_rise && vif.in_de) state_q <= ST_ACTIVE;
                ST_ACTIVE: if (vs_rise) state_q <= ST_WAIT;
                default:   state_q <= ST_SYNC;
            endcase
        end
    end

    always_comb begin
        x_d = x_q;
        if (vif.in_de) begin
            if (!de_d_q) begin
                x_d = '0;
            end else if (x_q != '1) begin
                x_d = x_inc;
            end
        end
    end

    always_comb begin
        y_d = y_q;
        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall && (y_q != '1)) begin
            y_d = y_q + YW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Pixels only pass once a frame boundary has been seen since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_de_q <= 1'b0;
            out_hs_q <= 1'b0;
            out_vs_q <= 1'b0;
        end else begin
            out_de_q <= vif.in_de & ~in_sync;
            out_hs_q <= vif.in_hs;
            out_vs_q <= vif.in_vs;
        end
    end

    assign err_set = (de_fall && !in_sync && (x_inc != H_RES_L)) ||
                     (vs_rise && !in_sync && (y_q != V_RES_L));

    always_comb begin
        res_err_d = res_err_q;
        if (err_set) begin
            res_err_d = 1'b1;
        end else if (vif.err_clr) begin
            res_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_w_q    <= '0;
            meas_h_q    <= '0;
            frame_cnt_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            res_err_q <= res_err_d;
            if (de_fall) begin
                meas_w_q <= x_inc;
            end
            if (vs_rise && !in_sync) begin
                meas_h_q    <= y_q;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // A write landing on the boundary cycle is applied directly, bypassing the pending register.
    assign cfg_apply = vs_rise & (pend_flag_q | vif.cfg_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_thr_q  <= '0;
            pend_en_q   <= 1'b0;
            pend_flag_q <= 1'b0;
            thr_q       <= '0;
            act_en_q    <= 1'b0;
            cfg_ack_q   <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_apply;
            if (vif.cfg_wr) begin
                pend_thr_q <= vif.cfg_thr;
                pend_en_q  <= vif.cfg_en;
            end
            if (cfg_apply) begin
                thr_q       <= vif.cfg_wr ? vif.cfg_thr : pend_thr_q;
                act_en_q    <= vif.cfg_wr ? vif.cfg_en : pend_en_q;
                pend_flag_q <= 1'b0;
            end else if (vif.cfg_wr) begin
                pend_flag_q <= 1'b1;
            end
        end
    end

    assign vif.out_de    = out_de_q;
    assign vif.out_hs    = out_hs_q;
    assign vif.out_vs    = out_vs_q;
    assign vif.x         = x_q;
    assign vif.y         = y_q;
    assign vif.sof       = out_de_q & (x_q == '0) & (y_q == '0);
    assign vif.eol       = out_de_q & de_fall;
    assign vif.eof       = out_de_q & de_fall & (y_q == V_LAST);
    assign vif.proc_en   = act_en_q & out_de_q;
    assign vif.thr       = thr_q;
    assign vif.cfg_ack   = cfg_ack_q;
    assign vif.state     = state_q;
    assign vif.frame_cnt = frame_cnt_q;
    assign vif.meas_w    = meas_w_q;
    assign vif.meas_h    = meas_h_q;
    assign vif.res_err   = res_err_q;

endmodule

// File: tb/tb_vis_frame_ctrl.sv
// Directed bench for vis_frame_ctrl: a table of whole frames with expected per-frame results,
// plus hand-written sequences for mid-frame reset, frame-counter wrap and clear/set collision.
module tb_vis_frame_ctrl;
    localparam int H    = 64;
    localparam int V    = 64;
    localparam int XW   = 11;
    localparam int YW   = 11;
    localparam int LINE = 83;
    localparam int NONE = -9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vis_frame_ctrl_if #(.XW(XW), .YW(YW)) vif ();

    vis_frame_ctrl #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW)) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor: per-frame event counters, sampled on falling edge
    int m_pix, m_proc, m_eol, m_eof, m_sof, m_ack, m_eol_bad, m_eof_pos, m_sof_pos, m_thr_glitch;
    int pix_in_frame = 0;
    logic prev_out_vs = 1'b0;
    logic [7:0] prev_thr = 8'd0;

    task automatic clr_mon();
        m_pix = 0; m_proc = 0; m_eol = 0; m_eof = 0; m_sof = 0; m_ack = 0;
        m_eol_bad = 0; m_eof_pos = -1; m_sof_pos = -1; m_thr_glitch = 0;
    endtask

    always @(negedge clk) begin
        if (vif.out_vs && !prev_out_vs) pix_in_frame = 0;
        prev_out_vs = vif.out_vs;
        if (vif.out_de) begin
            if (vif.sof) begin
                m_sof++;
                m_sof_pos = pix_in_frame;
            end
            pix_in_frame++;
            m_pix++;
        end
        if (vif.proc_en) m_proc++;
        if (vif.eol) begin
            if (vif.eof) m_eof_pos = m_eol;
            m_eol++;
            if (32'(vif.x) != H - 1) m_eol_bad++;
        end
        if (vif.eof) m_eof++;
        if (vif.cfg_ack) m_ack++;
        if (!rst && (vif.thr != prev_thr) && !vif.cfg_ack) m_thr_glitch++;
        prev_thr = vif.thr;
    end

    // ---------------- drivers
    typedef struct {
        int line;
        int thr;
        int en;
    } wr_t;
    wr_t wr_q[$];

    // lidx: active line index, -1 for the vsync-rise line, -2 for other blanking lines
    task automatic drive_line(input bit vs, input int w, input int lidx);
        wr_t t;
        for (int i = 0; i < LINE; i++) begin
            vif.in_vs  = vs;
            vif.in_de  = (i < w);
            vif.in_hs  = (i >= w + 8) && (i < w + 12);
            vif.cfg_wr = 1'b0;
            if (i == 0 && wr_q.size() > 0 && wr_q[0].line == lidx) begin
                t = wr_q.pop_front();
                vif.cfg_wr  = 1'b1;
                vif.cfg_thr = 8'(t.thr);
                vif.cfg_en  = t.en[0];
            end
            cyc();
        end
        vif.cfg_wr = 1'b0;
        vif.in_hs  = 1'b0;
    endtask

    task automatic vs_only(input bit clr);
        vif.in_vs   = 1'b1;
        vif.err_clr = clr;
        cyc();
        vif.err_clr = 1'b0;
        cyc();
        vif.in_vs = 1'b0;
        repeat (6) cyc();
    endtask

    // ---------------- frame vectors
    typedef struct {
        string name;
        int vsl, bp, fp, nlines, last_w, pre_clr;
        int w1_line, w1_thr, w1_en, w2_line, w2_thr, w2_en;
        int e_pre_state, e_pix, e_eol, e_eof, e_eof_pos, e_sof_pos, e_proc, e_ack;
        int e_state, e_fc, e_mw, e_mh, e_err, e_thr;
    } fvec_t;

    task automatic run_frame(input fvec_t v);
        int pre_state;
        clr_mon();
        if (v.w1_line != NONE) wr_q.push_back('{v.w1_line, v.w1_thr, v.w1_en});
        if (v.w2_line != NONE) wr_q.push_back('{v.w2_line, v.w2_thr, v.w2_en});
        if (v.pre_clr != 0) begin
            vif.err_clr = 1'b1;
            cyc();
            vif.err_clr = 1'b0;
        end
        for (int l = 0; l < v.vsl; l++) drive_line(1'b1, 0, (l == 0) ? -1 : -2);
        for (int l = 0; l < v.bp; l++) drive_line(1'b0, 0, -2);
        pre_state = 32'(vif.state);
        for (int l = 0; l < v.nlines; l++)
            drive_line(1'b0, (l == v.nlines - 1 && v.last_w > 0) ? v.last_w : H, l);
        for (int l = 0; l < v.fp; l++) drive_line(1'b0, 0, -2);

        chk({v.name, ".pre_state"}, 32'(pre_state), v.e_pre_state);
        chk({v.name, ".pix"},       m_pix,        v.e_pix);
        chk({v.name, ".eol"},       m_eol,        v.e_eol);
        chk({v.name, ".eol_x"},     m_eol_bad,    (v.last_w > 0) ? 1 : 0);
        chk({v.name, ".eof"},       m_eof,        v.e_eof);
        chk({v.name, ".eof_pos"},   m_eof_pos,    v.e_eof_pos);
        chk({v.name, ".sof"},       m_sof,        1);
        chk({v.name, ".sof_pos"},   m_sof_pos,    v.e_sof_pos);
        chk({v.name, ".proc"},      m_proc,       v.e_proc);
        chk({v.name, ".ack"},       m_ack,        v.e_ack);
        chk({v.name, ".thr_glit"},  m_thr_glitch, 0);
        chk({v.name, ".state"},     32'(vif.state),     v.e_state);
        chk({v.name, ".frame_cnt"}, 32'(vif.frame_cnt), v.e_fc);
        chk({v.name, ".meas_w"},    32'(vif.meas_w),    v.e_mw);
        chk({v.name, ".meas_h"},    32'(vif.meas_h),    v.e_mh);
        chk({v.name, ".res_err"},   32'(vif.res_err),   v.e_err);
        chk({v.name, ".thr"},       32'(vif.thr),       v.e_thr);
    endtask

    fvec_t tbl[8];
    fvec_t post_rst;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        //          name            vsl bp fp  nl lw clr  w1...              w2...            pre pix  eol eof pos sof proc ack st fc mw mh er thr
        tbl[0] = '{"t1_f0",          4, 8, 8, 64, 0, 0, NONE, 0, 0,       NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 0,    0, 2, 0, 64, 0,  0, 0};
        tbl[1] = '{"t1_f1",          4, 8, 8, 64, 0, 0, NONE, 0, 0,       NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 0,    0, 2, 1, 64, 64, 0, 0};
        tbl[2] = '{"t2_wr_mid",      4, 8, 8, 64, 0, 0, 10, 'h80, 1,      NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 0,    0, 2, 2, 64, 64, 0, 0};
        tbl[3] = '{"t2_apply",       1, 1, 1, 64, 0, 0, NONE, 0, 0,       NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 4096, 1, 2, 3, 64, 64, 0, 'h80};
        tbl[4] = '{"t3_two_wr",      1, 1, 1, 64, 0, 0, 2, 'h10, 1,       5, 'h20, 1,       1, 4096, 64, 1, 63, 0, 4096, 0, 2, 4, 64, 64, 0, 'h80};
        tbl[5] = '{"t4_short_line",  1, 1, 1, 64, 60, 0, NONE, 0, 0,      NONE, 0, 0,       1, 4092, 64, 1, 63, 0, 4092, 1, 2, 5, 60, 64, 1, 'h20};
        tbl[6] = '{"t4_63_lines",    1, 1, 1, 63, 0, 1, NONE, 0, 0,       NONE, 0, 0,       1, 4032, 63, 0, -1, 0, 4032, 0, 2, 6, 64, 64, 0, 'h20};
        tbl[7] = '{"t3_wr_at_vs",    1, 1, 1, 64, 0, 0, -1, 'h33, 0,      NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 0,    1, 2, 7, 64, 63, 1, 'h33};
        post_rst = '{"t5_after_rst", 1, 1, 1, 64, 0, 0, NONE, 0, 0,       NONE, 0, 0,       1, 4096, 64, 1, 63, 0, 0,    0, 2, 0, 64, 0,  0, 0};

        rst = 1'b1;
        vif.in_de = 1'b0; vif.in_hs = 1'b0; vif.in_vs = 1'b0;
        vif.cfg_wr = 1'b0; vif.cfg_thr = 8'd0; vif.cfg_en = 1'b0; vif.err_clr = 1'b0;
        clr_mon();
        repeat (3) cyc();

        chk("rst.state",     32'(vif.state),     0);
        chk("rst.out_de",    32'(vif.out_de),    0);
        chk("rst.x",         32'(vif.x),         0);
        chk("rst.y",         32'(vif.y),         0);
        chk("rst.thr",       32'(vif.thr),       0);
        chk("rst.frame_cnt", 32'(vif.frame_cnt), 0);
        chk("rst.meas_w",    32'(vif.meas_w),    0);
        chk("rst.res_err",   32'(vif.res_err),   0);
        chk("rst.cfg_ack",   32'(vif.cfg_ack),   0);
        rst = 1'b0;

        // Tail of a frame already in progress: nothing may reach the datapath before vsync.
        clr_mon();
        for (int l = 0; l < 3; l++) drive_line(1'b0, H, -2);
        chk("sync.pix",   m_pix, 0);
        chk("sync.eol",   m_eol, 0);
        chk("sync.state", 32'(vif.state), 0);

        for (int i = 0; i < 8; i++) run_frame(tbl[i]);

        // Reset in the middle of line 20 with a config write still pending.
        wr_q.push_back('{5, 'h55, 1});
        drive_line(1'b1, 0, -1);
        drive_line(1'b0, 0, -2);
        for (int l = 0; l < 20; l++) drive_line(1'b0, H, l);
        vif.in_de = 1'b1;
        repeat (30) cyc();
        rst = 1'b1;
        repeat (2) cyc();
        chk("t5.rst_state",   32'(vif.state),     0);
        chk("t5.rst_out_de",  32'(vif.out_de),    0);
        chk("t5.rst_proc_en", 32'(vif.proc_en),   0);
        chk("t5.rst_x",       32'(vif.x),         0);
        chk("t5.rst_y",       32'(vif.y),         0);
        chk("t5.rst_thr",     32'(vif.thr),       0);
        chk("t5.rst_fc",      32'(vif.frame_cnt), 0);
        chk("t5.rst_meas_h",  32'(vif.meas_h),    0);
        chk("t5.rst_res_err", 32'(vif.res_err),   0);
        rst = 1'b0;
        clr_mon();
        for (int i = 32; i < LINE; i++) begin
            vif.in_de = (i < H);
            cyc();
        end
        for (int l = 21; l < V; l++) drive_line(1'b0, H, -2);
        drive_line(1'b0, 0, -2);
        chk("t5.tail_pix",   m_pix, 0);
        chk("t5.tail_state", 32'(vif.state), 0);
        chk("t5.wr_q_empty", 32'(wr_q.size()), 0);
        run_frame(post_rst);

        // Frame counter wrap using vsync pulses with no active video.
        clr_mon();
        for (int i = 0; i < 255; i++) vs_only(1'b0);
        chk("t6.fc_255",   32'(vif.frame_cnt), 255);
        chk("t6.state",    32'(vif.state),     1);
        chk("t6.meas_h",   32'(vif.meas_h),    0);
        chk("t6.res_err",  32'(vif.res_err),   1);
        chk("t6.pix",      m_pix, 0);
        vif.err_clr = 1'b1;
        cyc();
        vif.err_clr = 1'b0;
        cyc();
        chk("t6.err_clr",  32'(vif.res_err),   0);
        vs_only(1'b1);
        chk("t6.fc_wrap",  32'(vif.frame_cnt), 0);
        chk("t6.set_wins", 32'(vif.res_err),   1);
        chk("t6.meas_h2",  32'(vif.meas_h),    0);
        chk("t6.state2",   32'(vif.state),     1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
